// File: rtl/board_renderer_if.sv
// ----------------------------------------------------------------------------
// board_renderer_if
//
// Row-fetch handshake between the board renderer (master) and the board store
// that supplies one packed board row per request (slave).
//
//   row_req   master -> slave  level request, held until row_ack
//   row_num   master -> slave  board row index, stable while row_req=1
//   row_ack   slave  -> master one-cycle strobe, row_data valid this cycle
//   row_data  slave  -> master packed row, cell c at [c*CELL_BITS +: CELL_BITS]
//
// DATA_W must equal BOARD_W*CELL_BITS of the renderer attached to it.
// ----------------------------------------------------------------------------
interface board_renderer_if #(
    parameter int DATA_W = 160
) ();
    logic              row_req;
    logic [7:0]        row_num;
    logic              row_ack;
    logic [DATA_W-1:0] row_data;

    modport master (
        output row_req,
        output row_num,
        input  row_ack,
        input  row_data
    );

    modport slave (
        input  row_req,
        input  row_num,
        output row_ack,
        output row_data
    );
endinterface

// File: rtl/board_renderer.sv
// ----------------------------------------------------------------------------
// board_renderer
//
// Draws a BOARD_W x BOARD_H grid of square cells onto a raster display. One
// board row is fetched per block row of SQ scan lines: the fetch is launched
// during horizontal blanking of the line just above the block row, buffered in
// a pending register and promoted to the display buffer at the end of that
// line, so the whole block row renders from a stable copy.
//
// Ports
//   i_clk       pixel clock, all state on its rising edge
//   i_rst       asynchronous active-high reset
//   bus         board_renderer_if.master row-fetch handshake
//   i_draw_x    current pixel column counter (10 bits)
//   i_draw_y    current pixel line counter (10 bits)
//   o_red       registered red   (latency 1 from i_draw_x/i_draw_y)
//   o_green     registered green
//   o_blue      registered blue
//   o_underrun  sticky: a requested row did not arrive before end of line
//
// Cell format: bits [11:0] are RGB444, R=[3:0], G=[7:4], B=[11:8]; a cell whose
// colour bits are all zero is empty and renders as BG_RGB.
// ----------------------------------------------------------------------------
module board_renderer #(
    parameter int          BOARD_W   = 10,
    parameter int          BOARD_H   = 20,
    parameter int          SQ        = 24,
    parameter int          X0        = 200,
    parameter int          Y0        = 0,
    parameter int          CELL_BITS = 16,
    parameter int          H_VIS     = 640,
    parameter int          H_TOTAL   = 800,
    parameter int          V_TOTAL   = 525,
    parameter int          GRID      = 1,
    parameter logic [23:0] BG_RGB    = 24'h003E7C,
    parameter logic [23:0] GRID_RGB  = 24'h202020
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    board_renderer_if.master        bus,
    input  logic [9:0]              i_draw_x,
    input  logic [9:0]              i_draw_y,
    output logic [7:0]              o_red,
    output logic [7:0]              o_green,
    output logic [7:0]              o_blue,
    output logic                    o_underrun
);

    localparam int ROW_BITS = BOARD_W * CELL_BITS;

    // Board extents held in 11 bits so X0+width never wraps when compared
    // against a zero-extended 10-bit coordinate.
    localparam logic [10:0] X_LO = 11'(X0);
    localparam logic [10:0] X_HI = 11'(X0 + BOARD_W * SQ);
    localparam logic [10:0] Y_LO = 11'(Y0);
    localparam logic [10:0] Y_HI = 11'(Y0 + BOARD_H * SQ);

    localparam logic [9:0] SQ_W     = 10'(SQ);
    localparam logic [9:0] X0_W     = 10'(X0);
    localparam logic [9:0] Y0_W     = 10'(Y0);
    localparam logic [9:0] H_VIS_W  = 10'(H_VIS);
    localparam logic [9:0] H_LAST_W = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST_W = 10'(V_TOTAL - 1);
    localparam logic [9:0] V_VIS_W  = 10'd480;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_HOLD = 2'd2;

    logic [1:0]          r_state;
    logic [7:0]          r_row_num;
    logic                r_underrun;
    logic [ROW_BITS-1:0] r_pend;
    logic [ROW_BITS-1:0] r_disp;
    logic [7:0]          r_red;
    logic [7:0]          r_green;
    logic [7:0]          r_blue;

    // ------------------------------------------------------------------
    // Fetch trigger: fires at the first blanking pixel of the line before
    // each block row, so the fetch has the whole blanking interval.
    // ------------------------------------------------------------------
    logic [9:0] w_next_y;
    logic [9:0] w_next_rel;
    logic       w_next_in;
    logic       w_trigger;
    logic       w_deadline;

    assign w_next_y   = (i_draw_y == V_LAST_W) ? 10'd0 : i_draw_y + 10'd1;
    assign w_next_rel = w_next_y - Y0_W;
    assign w_next_in  = ({1'b0, w_next_y} >= Y_LO) && ({1'b0, w_next_y} < Y_HI);
    assign w_trigger  = (i_draw_x == H_VIS_W) && w_next_in
                        && ((w_next_rel % SQ_W) == 10'd0);
    assign w_deadline = (i_draw_x == H_LAST_W);

    // ------------------------------------------------------------------
    // Fetch FSM and row buffers
    // ------------------------------------------------------------------
    // NOTE: every register here uses <= so all updates see pre-edge values;
    // mixing in = would make the result depend on statement order.
    // NOTE: the row buffers are reset as well so rows not yet fetched after
    // reset render as empty cells rather than X garbage.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state    <= ST_IDLE;
            r_row_num  <= 8'd0;
            r_underrun <= 1'b0;
            r_pend     <= '0;
            r_disp     <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_trigger) begin
                        r_row_num <= 8'(w_next_rel / SQ_W);
                        r_state   <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (bus.row_ack) begin
                        r_pend <= bus.row_data;
                        if (w_deadline) begin
                            // Data arrived on the last pixel: no HOLD cycle is
                            // left, so promote it straight to the display copy.
                            r_disp  <= bus.row_data;
                            r_state <= ST_IDLE;
                        end else begin
                            r_state <= ST_HOLD;
                        end
                    end else if (w_deadline) begin
                        // Late row: keep the old display copy (previous row
                        // repeats) and flag it until reset.
                        r_underrun <= 1'b1;
                        r_state    <= ST_IDLE;
                    end
                end
                ST_HOLD: begin
                    if (w_deadline) begin
                        r_disp  <= r_pend;
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.row_req = (r_state == ST_REQ);
    assign bus.row_num = r_row_num;
    assign o_underrun  = r_underrun;

    // ------------------------------------------------------------------
    // Pixel colour
    // ------------------------------------------------------------------
    logic [9:0]  w_rel_x;
    logic [9:0]  w_rel_y;
    logic [9:0]  w_cell_idx;
    logic        w_in_board;
    logic        w_visible;
    logic        w_on_grid;
    logic [11:0] w_cell_rgb;
    logic [23:0] w_rgb;

    assign w_rel_x    = i_draw_x - X0_W;
    assign w_rel_y    = i_draw_y - Y0_W;
    assign w_cell_idx = w_rel_x / SQ_W;
    assign w_in_board = ({1'b0, i_draw_x} >= X_LO) && ({1'b0, i_draw_x} < X_HI)
                        && ({1'b0, i_draw_y} >= Y_LO) && ({1'b0, i_draw_y} < Y_HI);
    assign w_visible  = (i_draw_x < H_VIS_W) && (i_draw_y < V_VIS_W);
    assign w_on_grid  = (GRID != 0)
                        && (((w_rel_x % SQ_W) == 10'd0) || ((w_rel_y % SQ_W) == 10'd0));

    // Cell mux written as a compare loop so an out-of-range index (pixel off
    // the board) selects nothing instead of slicing past the row.
    // NOTE: w_cell_rgb gets a default before the loop; without it the
    // no-match path would infer a latch.
    always_comb begin
        w_cell_rgb = 12'h000;
        for (int c = 0; c < BOARD_W; c++) begin
            if (w_cell_idx == 10'(c)) begin
                w_cell_rgb = r_disp[c*CELL_BITS +: 12];
            end
        end
    end

    // Cell bits above the colour field are carried through the buffers but
    // not rendered; fold them into a sink so they are visibly intentional.
    logic w_unused_disp;
    assign w_unused_disp = ^r_disp;

    always_comb begin
        w_rgb = 24'h000000;
        if (w_in_board) begin
            if (w_on_grid) begin
                w_rgb = GRID_RGB;
            end else if (w_cell_rgb == 12'h000) begin
                w_rgb = BG_RGB;
            end else begin
                // RGB444 -> RGB888 by nibble replication (F -> FF, 0 -> 00).
                w_rgb = {w_cell_rgb[3:0],  w_cell_rgb[3:0],
                         w_cell_rgb[7:4],  w_cell_rgb[7:4],
                         w_cell_rgb[11:8], w_cell_rgb[11:8]};
            end
        end else if (w_visible) begin
            w_rgb = BG_RGB;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_red   <= 8'd0;
            r_green <= 8'd0;
            r_blue  <= 8'd0;
        end else begin
            r_red   <= w_rgb[23:16];
            r_green <= w_rgb[15:8];
            r_blue  <= w_rgb[7:0];
        end
    end

    assign o_red   = r_red;
    assign o_green = r_green;
    assign o_blue  = r_blue;

endmodule

// File: tb/tb_board_renderer.sv
// ----------------------------------------------------------------------------
// tb_board_renderer
//
// Directed bench for board_renderer. Drives the pixel counters by hand, plays
// the board store on the row-fetch interface, and compares outputs one pixel
// after the counters are applied. A second instance with BOARD_W=12, SQ=20,
// X0=80 checks the wide-row cell selection.
// ----------------------------------------------------------------------------
module tb_board_renderer;

    localparam int DW_A = 10 * 16;
    localparam int DW_B = 12 * 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [9:0] draw_x = '0;
    logic [9:0] draw_y = '0;

    logic [7:0] red_a, green_a, blue_a, red_b, green_b, blue_b;
    logic       underrun_a, underrun_b;

    int n_checks = 0;
    int n_fail   = 0;

    board_renderer_if #(.DATA_W(DW_A)) if_a ();
    board_renderer_if #(.DATA_W(DW_B)) if_b ();

    board_renderer u_dut_a (
        .i_clk      (clk),
        .i_rst      (rst),
        .bus        (if_a.master),
        .i_draw_x   (draw_x),
        .i_draw_y   (draw_y),
        .o_red      (red_a),
        .o_green    (green_a),
        .o_blue     (blue_a),
        .o_underrun (underrun_a)
    );

    board_renderer #(.BOARD_W(12), .SQ(20), .X0(80)) u_dut_b (
        .i_clk      (clk),
        .i_rst      (rst),
        .bus        (if_b.master),
        .i_draw_x   (draw_x),
        .i_draw_y   (draw_y),
        .o_red      (red_b),
        .o_green    (green_b),
        .o_blue     (blue_b),
        .o_underrun (underrun_b)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [9:0]  x;
        logic [9:0]  y;
        logic [23:0] rgb;
    } vec_t;

    vec_t vecs[15];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [23:0] rgb_a();
        return {red_a, green_a, blue_a};
    endfunction

    function automatic logic [23:0] rgb_b();
        return {red_b, green_b, blue_b};
    endfunction

    // Walk line y from x_from to x_to, one pixel per clock. The selected
    // store (A or B) strobes row_ack with data at x == ack_x (-1: never).
    // Returns 1 ns after the last active edge, so outputs reflect pixel x_to.
    task automatic run_line(input logic [9:0] y, input int x_from, input int x_to,
                            input int ack_x, input logic to_b, input logic [DW_B-1:0] data);
        for (int x = x_from; x <= x_to; x++) begin
            @(negedge clk);
            draw_x        = 10'(x);
            draw_y        = y;
            if_a.row_data = data[DW_A-1:0];
            if_b.row_data = data;
            if_a.row_ack  = (x == ack_x) && !to_b;
            if_b.row_ack  = (x == ack_x) && to_b;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pixel(input int x, input logic [9:0] y);
        run_line(y, x, x, -1, 1'b0, '0);
    endtask

    logic [DW_B-1:0] d;

    initial begin
        // Pixel vectors against the row-1 contents loaded below:
        // cell0=0F00 cell2=0123 cell5=0FFF cell9=F0A5, rest empty.
        vecs[0]  = '{"cell0_blue",     10'd201, 10'd25,  24'h0000FF};
        vecs[1]  = '{"grid_col_224",   10'd224, 10'd30,  24'h202020};
        vecs[2]  = '{"empty_cell1",    10'd230, 10'd30,  24'h003E7C};
        vecs[3]  = '{"cell2_rgb",      10'd250, 10'd26,  24'h332211};
        vecs[4]  = '{"grid_left_edge", 10'd200, 10'd30,  24'h202020};
        vecs[5]  = '{"grid_row_48",    10'd210, 10'd48,  24'h202020};
        vecs[6]  = '{"sidebar_100",    10'd100, 10'd30,  24'h003E7C};
        vecs[7]  = '{"hblank_700",     10'd700, 10'd30,  24'h000000};
        vecs[8]  = '{"cell5_bottom",   10'd321, 10'd479, 24'hFFFFFF};
        vecs[9]  = '{"cell9_last_px",  10'd439, 10'd30,  24'h55AA00};
        vecs[10] = '{"right_of_board", 10'd440, 10'd30,  24'h003E7C};
        vecs[11] = '{"vblank_480",     10'd300, 10'd480, 24'h000000};
        vecs[12] = '{"sidebar_corner", 10'd639, 10'd479, 24'h003E7C};
        vecs[13] = '{"hblank_640",     10'd640, 10'd10,  24'h000000};
        vecs[14] = '{"left_of_board",  10'd199, 10'd30,  24'h003E7C};

        if_a.row_ack  = 1'b0;
        if_b.row_ack  = 1'b0;
        if_a.row_data = '0;
        if_b.row_data = '0;

        // ---------------- reset state ----------------
        repeat (3) @(posedge clk);
        #1;
        check("rst_row_req",  32'(if_a.row_req), 32'd0);
        check("rst_row_num",  32'(if_a.row_num), 32'd0);
        check("rst_underrun", 32'(underrun_a),   32'd0);
        check("rst_rgb",      32'(rgb_a()),      32'd0);
        check("rst_b_req",    32'(if_b.row_req), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // ---------------- wide board (instance B) ----------------
        pixel(640, 10'd19);
        check("b_row_req", 32'(if_b.row_req), 32'd1);
        check("b_row_num", 32'(if_b.row_num), 32'd1);
        d = '0;
        d[191:176] = 16'h0F00;
        d[175:160] = 16'h00F0;
        run_line(10'd19, 641, 799, 650, 1'b1, d);
        pixel(299, 10'd21);
        check("b_cell10_end",   32'(rgb_b()), 32'h00FF00);
        pixel(301, 10'd21);
        check("b_cell11_start", 32'(rgb_b()), 32'h0000FF);
        pixel(319, 10'd21);
        check("b_cell11_end",   32'(rgb_b()), 32'h0000FF);
        pixel(320, 10'd21);
        check("b_right_edge",   32'(rgb_b()), 32'h003E7C);

        // ---------------- row 1 fetch, normal ack ----------------
        pixel(640, 10'd23);
        check("r1_row_req", 32'(if_a.row_req), 32'd1);
        check("r1_row_num", 32'(if_a.row_num), 32'd1);
        d = '0;
        d[15:0]    = 16'h0F00;
        d[47:32]   = 16'h0123;
        d[95:80]   = 16'h0FFF;
        d[159:144] = 16'hF0A5;
        run_line(10'd23, 641, 650, 650, 1'b0, d);
        check("r1_req_dropped", 32'(if_a.row_req), 32'd0);
        run_line(10'd23, 651, 799, -1, 1'b0, '0);

        for (int i = 0; i < 15; i++) begin
            pixel(int'(vecs[i].x), vecs[i].y);
            check(vecs[i].name, 32'(rgb_a()), 32'(vecs[i].rgb));
        end

        // ---------------- frame wrap: row 0 fetched on line 524 ----------------
        pixel(640, 10'd524);
        check("wrap_row_req", 32'(if_a.row_req), 32'd1);
        check("wrap_row_num", 32'(if_a.row_num), 32'd0);
        d = '0;
        d[15:0] = 16'h000F;
        run_line(10'd524, 641, 799, 641, 1'b0, d);
        pixel(201, 10'd1);
        check("wrap_row0_shown", 32'(rgb_a()), 32'hFF0000);

        // ---------------- ack on the deadline pixel ----------------
        pixel(640, 10'd71);
        check("dl_row_num", 32'(if_a.row_num), 32'd3);
        d = '0;
        d[15:0] = 16'h00F0;
        run_line(10'd71, 641, 799, 799, 1'b0, d);
        check("dl_row_req", 32'(if_a.row_req), 32'd0);
        check("dl_underrun", 32'(underrun_a), 32'd0);
        pixel(201, 10'd73);
        check("dl_shown", 32'(rgb_a()), 32'h00FF00);

        // ---------------- underrun: ack withheld ----------------
        pixel(640, 10'd95);
        check("ur_row_num", 32'(if_a.row_num), 32'd4);
        run_line(10'd95, 641, 799, -1, 1'b0, '0);
        check("ur_underrun", 32'(underrun_a), 32'd1);
        check("ur_row_req", 32'(if_a.row_req), 32'd0);
        pixel(201, 10'd97);
        check("ur_prev_repeats", 32'(rgb_a()), 32'h00FF00);

        // A stray ack while idle must not change the display.
        d = '0;
        d[15:0] = 16'h0FFF;
        run_line(10'd97, 650, 799, 650, 1'b0, d);
        pixel(201, 10'd98);
        check("stray_ack_ignored", 32'(rgb_a()), 32'h00FF00);
        check("ur_sticky", 32'(underrun_a), 32'd1);

        // ---------------- asynchronous reset while in REQ ----------------
        pixel(640, 10'd119);
        check("ar_row_req_before", 32'(if_a.row_req), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("ar_row_req", 32'(if_a.row_req), 32'd0);
        check("ar_rgb", 32'(rgb_a()), 32'd0);
        check("ar_underrun", 32'(underrun_a), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        pixel(201, 10'd121);
        check("ar_display_cleared", 32'(rgb_a()), 32'h003E7C);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/board_renderer.md
BOARD_RENDERER -- requirements
Module: board_renderer

Interface
REQ-001 Parameter BOARD_W, default 10, meaning cells per board row.
REQ-002 Parameter BOARD_H, default 20, meaning board rows.
REQ-003 Parameter SQ, default 24, meaning cell edge in pixels (square cells).
REQ-004 Parameter X0, default 200, meaning board left edge in pixels; Y0, default 0, meaning board top edge in pixels.
REQ-005 Parameter CELL_BITS, default 16, meaning bits per cell; bits [11:0] are RGB444 with R=[3:0], G=[7:4], B=[11:8].
REQ-006 Parameter H_VIS=640, H_TOTAL=800, V_TOTAL=525, meaning visible width and total horizontal/vertical counts.
REQ-007 Parameter GRID, default 1, meaning draw 1-pixel grid lines when 1.
REQ-008 Parameter BG_RGB, default 24'h003E7C, meaning side-bar/empty-cell colour; GRID_RGB, default 24'h202020, meaning grid colour.
REQ-009 Clk  in  1  pixel clock; all state rises on posedge Clk.
REQ-010 Reset  in  1  asynchronous, active-high reset.
REQ-011 DrawX, DrawY  in  10 each  current pixel counters.
REQ-012 row_req  out  1  row fetch request, level, held until ack.
REQ-013 row_num  out  8  board row requested, stable while row_req=1.
REQ-014 row_ack  in  1  one-cycle strobe: row_data valid this cycle.
REQ-015 row_data  in  BOARD_W*CELL_BITS  cell c at bits [c*CELL_BITS +: CELL_BITS].
REQ-016 Red, Green, Blue  out  8 each  registered pixel colour.
REQ-017 underrun  out  1  sticky flag: a row was not delivered in time.

Function
REQ-018 next_y = 0 when DrawY = V_TOTAL-1, else DrawY+1; trigger = (DrawX = H_VIS) and Y0 <= next_y < Y0+BOARD_H*SQ and (next_y-Y0) mod SQ = 0.
REQ-019 FSM states IDLE, REQ, HOLD; reset state IDLE.
REQ-020 IDLE: on trigger, latch row_num = (next_y-Y0)/SQ, go to REQ.
REQ-021 REQ: row_req=1; on row_ack, capture row_data into pending buffer, go to HOLD.
REQ-022 HOLD: at DrawX = H_TOTAL-1 copy pending into display buffer, go to IDLE.
REQ-023 REQ at DrawX = H_TOTAL-1 without row_ack: set underrun, drop row_req, go to IDLE, display buffer unchanged (previous row repeats).
REQ-024 row_ack in the same cycle as the REQ deadline: data accepted, copy direct to display, no underrun.
REQ-025 row_ack while not in REQ is ignored.
REQ-026 trigger in REQ or HOLD is ignored (cannot occur with SQ>=1 and H_TOTAL>H_VIS+1; not an error).
REQ-027 Pixel inside board: X0 <= DrawX < X0+BOARD_W*SQ and Y0 <= DrawY < Y0+BOARD_H*SQ; cell c = (DrawX-X0)/SQ.
REQ-028 Inside board, GRID=1, and (DrawX-X0) mod SQ = 0 or (DrawY-Y0) mod SQ = 0: GRID_RGB.
REQ-029 Otherwise inside board: if cell[11:0] = 0, BG_RGB; else Red={R,R}, Green={G,G}, Blue={B,B} (nibble replication).
REQ-030 Outside board but DrawX < H_VIS and DrawY < 480: BG_RGB; blanking region (DrawX >= H_VIS or DrawY >= 480): all zero.
REQ-031 Colour outputs registered: value for pixel (X,Y) appears the cycle after DrawX=X, DrawY=Y (latency 1).
REQ-032 All divide/modulo by SQ done on widths sized for 10-bit coordinates; no truncation for BOARD_W*SQ <= 640.

Reset
REQ-033 Reset asserted: state IDLE, row_req=0, row_num=0, underrun=0, pending and display buffers all zero, Red/Green/Blue=0, immediately and independent of Clk.
REQ-034 Reset deasserted mid-frame: first trigger after release starts normal operation; rows before it render as empty (BG_RGB).
REQ-035 underrun clears only on Reset.

Verification
REQ-036 Defaults, DrawY=23, DrawX=640 -> row_req=1, row_num=1 next cycle; ack with cell0=16'h0F00 at DrawX=650 -> at DrawY=25, DrawX=201 Red=00, Green=00, Blue=FF one cycle later.
REQ-037 DrawY=524, DrawX=640 -> row_num=0 request; ack -> row 0 shown from DrawY=0.
REQ-038 Withhold ack through DrawX=799 -> underrun=1, row_req=0, previous row's colours repeat on next block row.
REQ-039 GRID=1, DrawX=224, DrawY=30 -> GRID_RGB; DrawX=100 -> 00/3E/7C; DrawX=700 -> 00/00/00.
REQ-040 Ack on the deadline cycle -> data displayed, underrun stays 0; Reset in REQ -> row_req=0 and outputs zero asynchronously.
REQ-041 Parameters BOARD_W=12, SQ=20, X0=80 -> cell 11 spans DrawX 300..319; cell bits [191:176] are selected.
